// File: rtl/dec84n2n1_pack_if.sv
// rtl/dec84n2n1_pack_if.sv - codeword input and packed-BCD output handshake bundle
interface dec84n2n1_pack_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_code;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_err;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_bcd, out_err
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_bcd, out_err
  );
endinterface

// File: rtl/dec84n2n1_pack.sv
// rtl/dec84n2n1_pack.sv - 8,4,-2,-1 decoder packing DIGITS digits per word; DEC84_ERRCNT_EN adds err_count
module dec84n2n1_pack #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  dec84n2n1_pack_if.slave  bus
`ifdef DEC84_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic                err_acc;
  logic [4*DIGITS-1:0] shreg;
  logic [4*DIGITS-1:0] shifted;
  logic [3:0]          digit;
  logic                bad;
  logic                rdy;
  logic                vld;
  logic                in_xfer;
  logic                out_xfer;
  logic                last;

  always_comb begin
    digit = 4'd0;
    bad   = 1'b0;
    case (bus.in_code)
      4'b0000: digit = 4'd0;
      4'b0111: digit = 4'd1;
      4'b0110: digit = 4'd2;
      4'b0101: digit = 4'd3;
      4'b0100: digit = 4'd4;
      4'b1011: digit = 4'd5;
      4'b1010: digit = 4'd6;
      4'b1001: digit = 4'd7;
      4'b1000: digit = 4'd8;
      4'b1111: digit = 4'd9;
      default: bad   = 1'b1;
    endcase
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign shifted = digit;
    end else begin : g_many
      assign shifted = {shreg[4*DIGITS-5:0], digit};
    end
  endgenerate

  assign in_xfer  = bus.in_valid & rdy;
  assign out_xfer = vld & bus.out_ready;
  assign last     = (cnt == CW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (in_xfer && last) state_nx = HOLD;
      HOLD:    if (out_xfer)        state_nx = FILL;
      default:                      state_nx = FILL;
    endcase
  end

  always_comb begin
    rdy = (state == FILL);
    vld = (state == HOLD);
  end

  // The shift register doubles as the output word: it cannot move while in HOLD.
  always_ff @(posedge clk) begin
    if (rst || out_xfer) begin
      cnt     <= '0;
      err_acc <= 1'b0;
      shreg   <= '0;
    end else if (in_xfer) begin
      shreg   <= shifted;
      cnt     <= cnt + CW'(1);
      err_acc <= err_acc | bad;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_bcd   = shreg;
  assign bus.out_err   = err_acc;

`ifdef DEC84_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= 8'd0;
    else if (in_xfer && bad && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_dec84n2n1_pack.sv
// tb/tb_dec84n2n1_pack.sv - randomized self-checking bench for dec84n2n1_pack
module tb_dec84n2n1_pack;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dec84n2n1_pack_if #(.DIGITS(DIGITS)) bus ();
`ifdef DEC84_ERRCNT_EN
  logic [7:0] err_count;
`endif

  dec84n2n1_pack #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef DEC84_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Reference: value under weights 8,4,-2,-1; the code is valid iff it lands in 0..9.
  function automatic int weight_val(input logic [3:0] c);
    return 8 * c[3] + 4 * c[2] - 2 * c[1] - 1 * c[0];
  endfunction

  function automatic bit code_ok(input logic [3:0] c);
    int v;
    v = weight_val(c);
    return (v >= 0) && (v <= 9);
  endfunction

  function automatic logic [15:0] model_word(input logic [3:0] c [4]);
    logic [15:0] w;
    w = 16'd0;
    for (int i = 0; i < 4; i++)
      w = w * 16 + (code_ok(c[i]) ? 16'(weight_val(c[i])) : 16'd0);
    return w;
  endfunction

  function automatic bit model_err(input logic [3:0] c [4]);
    bit e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) e = e | !code_ok(c[i]);
    return e;
  endfunction

  task automatic push(input logic [3:0] c);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.out_valid;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_bcd !== 16'h0) begin bad++; $display("FAIL reset_out_bcd got=%h exp=0000", bus.out_bcd); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
  endtask

  task automatic test_basic();
    logic [3:0] c [4] = '{4'b0111, 4'b0110, 4'b0101, 4'b0100};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid digit=%0d got=%b exp=0", i, bus.out_valid); end
      push(c[i]);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency out_valid=%b exp=1", bus.out_valid); end
    total++; if (bus.out_bcd !== model_word(c)) begin bad++; $display("FAIL basic_bcd got=%h exp=%h", bus.out_bcd, model_word(c)); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", bus.out_err); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_single_hold out_valid=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_hold_stall();
    logic [3:0] c [4] = '{4'b1011, 4'b1010, 4'b1001, 4'b1111};
    bit ok;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(c[i]);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout out_valid=%b exp=1", bus.out_valid); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_bcd !== 16'h5679) begin
        bad++;
        $display("FAIL stall_cycle%0d valid=%b ready=%b bcd=%h exp=1/0/5679", k, bus.out_valid, bus.in_ready, bus.out_bcd);
      end
      @(negedge clk);
    end
    pop();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_single_xfer out_valid=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_invalid();
    logic [3:0] c [4] = '{4'b0000, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] g [4] = '{4'b1111, 4'b0000, 4'b0111, 4'b1000};
    bit ok;
    for (int i = 0; i < 4; i++) push(c[i]);
    wait_valid(ok);
    total++; if (!ok || bus.out_bcd !== 16'h0080) begin bad++; $display("FAIL invalid_bcd got=%h exp=0080", bus.out_bcd); end
    total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL invalid_err got=%b exp=1", bus.out_err); end
    pop();
    for (int i = 0; i < 4; i++) push(g[i]);
    wait_valid(ok);
    total++; if (!ok || bus.out_bcd !== model_word(g)) begin bad++; $display("FAIL clean_bcd got=%h exp=%h", bus.out_bcd, model_word(g)); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL clean_err got=%b exp=0", bus.out_err); end
    pop();
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(4'b1111);
    push(4'b1000);
    pulse_rst();
    total++; if (bus.out_bcd !== 16'h0) begin bad++; $display("FAIL midrst_clear got=%h exp=0000", bus.out_bcd); end
    for (int i = 0; i < 3; i++) push(4'b0111);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_count out_valid=%b exp=0 after 3 digits", bus.out_valid); end
    push(4'b0111);
    wait_valid(ok);
    total++; if (!ok || bus.out_bcd !== 16'h1111) begin bad++; $display("FAIL midrst_bcd got=%h exp=1111", bus.out_bcd); end
    pop();
  endtask

  task automatic test_hold_ignore();
    logic [3:0] c [4] = '{4'b0100, 4'b0101, 4'b0110, 4'b1001};
    logic [3:0] d [4] = '{4'b0111, 4'b1000, 4'b1011, 4'b0000};
    bit ok;
    for (int i = 0; i < 4; i++) push(c[i]);
    bus.in_valid = 1'b1;
    bus.in_code  = 4'b0111;
    for (int k = 0; k < 3; k++) @(negedge clk);
    total++; if (bus.out_bcd !== model_word(c)) begin bad++; $display("FAIL ignore_bcd got=%h exp=%h", bus.out_bcd, model_word(c)); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ignore_bubble in_ready=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) push(d[i]);
    wait_valid(ok);
    total++; if (!ok || bus.out_bcd !== model_word(d)) begin bad++; $display("FAIL ignore_resume got=%h exp=%h", bus.out_bcd, model_word(d)); end
    pop();
  endtask

  task automatic test_random();
    logic [3:0] c [4];
    logic [15:0] snap;
    bit ok;
    for (int w = 0; w < 25; w++) begin
      for (int i = 0; i < 4; i++) begin
        c[i] = 4'($urandom_range(0, 15));
        for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        push(c[i]);
      end
      wait_valid(ok);
      snap = bus.out_bcd;
      for (int s = $urandom_range(0, 3); s > 0; s--) @(negedge clk);
      total++;
      if (!ok || bus.out_bcd !== model_word(c) || bus.out_err !== model_err(c) || bus.out_bcd !== snap) begin
        bad++;
        $display("FAIL random_word%0d bcd=%h err=%b exp=%h/%b", w, bus.out_bcd, bus.out_err, model_word(c), model_err(c));
      end
      pop();
    end
  endtask

`ifdef DEC84_ERRCNT_EN
  task automatic test_errcnt();
    pulse_rst();
    for (int i = 0; i < 300; i++) begin
      push(4'b1110);
      if (bus.out_valid) pop();
      if (i == 99) begin
        total++; if (err_count !== 8'd100) begin bad++; $display("FAIL errcnt_mid got=%0d exp=100", err_count); end
      end
    end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL errcnt_sat got=%0d exp=255", err_count); end
    pulse_rst();
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL errcnt_rst got=%0d exp=0", err_count); end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = 4'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold_stall();
    test_invalid();
    test_reset_mid();
    test_hold_ignore();
    test_random();
`ifdef DEC84_ERRCNT_EN
    test_errcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec84n2n1_pack.md
Name: dec84n2n1_pack

Overview:
Receiving end of the BCD-to-8,4,-2,-1 weighted-code link. It accepts one 4-bit 8,4,-2,-1 codeword per valid/ready handshake and decodes it to a BCD digit. It packs DIGITS decoded digits into one packed-BCD word, most significant digit first, and presents the word on a valid/ready output port. Codewords outside the code set are flagged, not silently passed.

Parameters:
DIGITS, 4, number of BCD digits packed per output word (legal range 1..8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_code holds a codeword
in_ready  output  1  block can accept a codeword this cycle
in_code  input  4  8,4,-2,-1 codeword, bit 3 weight 8, bit 0 weight -1
out_valid  output  1  out_bcd/out_err hold a complete word
out_ready  input  1  downstream accepts the word
out_bcd  output  4*DIGITS  packed BCD, digit DIGITS-1 in the top nibble = first received
out_err  output  1  at least one codeword in this word was invalid

Behaviour:
- Decode table (code -> digit):
  - 0000->0, 0111->1, 0110->2, 0101->3, 0100->4
  - 1011->5, 1010->6, 1001->7, 1000->8, 1111->9
- Invalid codes 0001, 0010, 0011, 1100, 1101, 1110:
  - the digit is stored as 0000
  - the word's sticky error bit is set
- States:
  - FILL: in_ready=1, out_valid=0
  - HOLD: in_ready=0, out_valid=1
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- FILL:
  - Each input transfer shifts the shift register left 4 bits, inserting the decoded digit at nibble 0.
  - Each input transfer increments the digit counter (width clog2(DIGITS+1)) and ORs the invalid flag into err_acc.
  - On the transfer that brings the count to DIGITS, next state is HOLD. out_bcd = shifted register and out_err = err_acc, both registered, visible the next cycle.
  - Latency: out_valid rises exactly 1 cycle after the last input handshake.
- HOLD:
  - out_bcd and out_err stay stable while out_valid=1 and out_ready=0.
  - On an output transfer, next state is FILL, with digit counter, err_acc and shift register cleared.
  - in_ready=0 throughout HOLD, so there is a one-cycle bubble: the next codeword can be accepted in the cycle after the output transfer.
- DIGITS=1: every accepted codeword produces a word; alternates FILL and HOLD.
- in_valid while in HOLD: ignored, no state change; the source must hold the codeword.
- out_ready while in FILL: no effect.
- Reset values:
  - state=FILL, in_ready=1, out_valid=0
  - out_bcd=0, out_err=0
  - counter=0, err_acc=0
- Reset mid-operation: a partially filled word is discarded, and a word in HOLD is dropped without handshake.
- rst has priority over any simultaneous handshake in the same cycle.
- Outputs are purely registered: no combinational path from in_code to out_bcd.

Optional Feature:
Macro DEC84_ERRCNT_EN.
- Defined:
  - Extra output port err_count, output, 8 bits.
  - Saturating count of invalid codewords accepted since reset.
  - Increments by 1 on each input transfer carrying an invalid code.
  - Holds at 255; reset value 0.
  - Not cleared by word completion.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then DIGITS=4 codewords 0111, 0110, 0101, 0100 back-to-back, out_ready=1 -> out_valid one cycle after the 4th handshake, out_bcd=16'h1234, out_err=0; in_ready low for exactly the HOLD cycle.
- Codes 1011, 1010, 1001, 1111 with out_ready=0 for 5 cycles -> out_bcd=16'h5679 held stable and in_ready=0 for all 5 cycles; single output transfer when out_ready rises, then in_ready=1 the following cycle.
- Codes 0000, 1100, 1000, 0001 -> out_bcd=16'h0080, out_err=1; the next word of all valid codes reports out_err=0.
- Two codes accepted, rst pulsed for 1 cycle, then 0111, 0111, 0111, 0111 -> out_bcd=16'h1111; the pre-reset digits never appear.
- in_valid held high with 0111 while in HOLD for 3 cycles -> no extra digits captured; the count resumes only after the output transfer.
- With DEC84_ERRCNT_EN: 300 invalid codewords (code 1110) -> err_count saturates at 255; rst -> err_count=0.
